// File: rtl/taylor_pkg.sv
// Shared constants and controller state encoding for the Taylor cosine sweep controller.
// Angles and results are signed fixed point with FRAC fractional bits.
package taylor_pkg;

    localparam int unsigned W           = 25;
    localparam int unsigned FRAC        = 23;
    localparam int          FXP_ONE     = 8388608;
    localparam int unsigned TIMEOUT_CYC = 64;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StStore,
        StFinish
    } state_e;

endpackage

// File: rtl/taylor_result_fifo.sv
// Result buffer for the sweep controller: FIFO-ordered, DEPTH a power of two.
// A pop on an empty buffer is ignored; push and pop together keep occupancy.
module taylor_result_fifo #(
    parameter int unsigned W     = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_eff, pop_eff;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (AW + 1)'(DEPTH));
    assign count_o  = count_q;
    assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    assign pop_eff  = pop_i && !empty_o;
    // When full, a simultaneous pop frees the slot being written.
    assign push_eff = push_i && (!full_o || pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_eff && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!push_eff && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/taylor_sweep_ctrl.sv
// Sweeps a cosine engine over an arithmetic angle sequence and buffers the results.
// Optional WAIT watchdog enabled by defining TAYLOR_SWEEP_TIMEOUT_EN.
module taylor_sweep_ctrl
    import taylor_pkg::*;
#(
    parameter int unsigned W         = taylor_pkg::W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ISSUE_CYC = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sweep_go_i,
    input  logic [W-1:0] angle_first_i,
    input  logic [W-1:0] angle_step_i,
    input  logic [7:0]   sweep_len_i,
    output logic         eng_start_o,
    output logic [W-1:0] eng_angle_o,
    input  logic         eng_ready_i,
    input  logic [W-1:0] eng_cos_i,
    output logic         res_valid_o,
    output logic [W-1:0] res_data_o,
    input  logic         res_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned ICW = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   angle_q, angle_d;
    logic [W-1:0]   step_q, step_d;
    logic [7:0]     remaining_q, remaining_d;
    logic [7:0]     remaining_after;
    logic           pending_q, pending_d;
    logic [ICW-1:0] issue_cnt_q, issue_cnt_d;
    logic           seen_low_q, seen_low_d;
    logic [W-1:0]   cap_q, cap_d;
    logic           pushed_q, pushed_d;

    logic           fifo_full, fifo_empty, pop_eff, store_push, free_slot;
    logic [CW-1:0]  fifo_count;

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    logic [5:0]     wait_cnt_q, wait_cnt_d;
    logic           error_q, error_d;
`endif

    assign pop_eff         = res_ready_i && !fifo_empty;
    assign store_push      = (state_q == StStore) && !pushed_q;
    assign remaining_after = pushed_q ? remaining_q : remaining_q - 8'd1;
    // Free slot accounts for the result being pushed this cycle and any pop alongside it.
    assign free_slot = store_push ? ((fifo_count < CW'(DEPTH - 1)) || pop_eff)
                                  : (!fifo_full || pop_eff);

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        pending_d   = pending_q;
        issue_cnt_d = issue_cnt_q;
        seen_low_d  = seen_low_q;
        cap_d       = cap_q;
        pushed_d    = pushed_q;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
        error_d     = error_q;
        wait_cnt_d  = (state_q == StWait) ? wait_cnt_q + 6'd1 : '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    if (free_slot) begin
                        pending_d   = 1'b0;
                        issue_cnt_d = '0;
                        state_d     = StIssue;
                    end
                end else if (sweep_go_i) begin
                    angle_d     = angle_first_i;
                    step_d      = angle_step_i;
                    remaining_d = sweep_len_i;
                    if (sweep_len_i == 8'd0) begin
                        state_d = StFinish;
                    end else if (free_slot) begin
                        issue_cnt_d = '0;
                        state_d     = StIssue;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (issue_cnt_q == ICW'(ISSUE_CYC - 1)) begin
                    seen_low_d = 1'b0;
                    state_d    = StWait;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            StWait: begin
                // A ready left high by the previous request is ignored until it drops.
                if (seen_low_q && eng_ready_i) begin
                    cap_d    = eng_cos_i;
                    pushed_d = 1'b0;
                    state_d  = StStore;
                end else begin
                    if (!eng_ready_i) begin
                        seen_low_d = 1'b1;
                    end
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
                    if (wait_cnt_q == 6'(TIMEOUT_CYC - 1)) begin
                        error_d = 1'b1;
                        state_d = StFinish;
                    end
`endif
                end
            end
            StStore: begin
                if (!pushed_q) begin
                    pushed_d    = 1'b1;
                    angle_d     = angle_q + step_q;
                    remaining_d = remaining_q - 8'd1;
                end
                if (remaining_after == 8'd0) begin
                    state_d = StFinish;
                end else if (free_slot) begin
                    issue_cnt_d = '0;
                    state_d     = StIssue;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            angle_q     <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            pending_q   <= 1'b0;
            issue_cnt_q <= '0;
            seen_low_q  <= 1'b0;
            cap_q       <= '0;
            pushed_q    <= 1'b0;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            issue_cnt_q <= issue_cnt_d;
            seen_low_q  <= seen_low_d;
            cap_q       <= cap_d;
            pushed_q    <= pushed_d;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            error_q     <= error_d;
`endif
        end
    end

    taylor_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (store_push),
        .push_data_i (cap_q),
        .pop_i       (res_ready_i),
        .head_o      (res_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign eng_start_o = (state_q == StIssue);
    assign eng_angle_o = angle_q;
    assign res_valid_o = !fifo_empty;
    assign done_o      = (state_q == StFinish);
    assign busy_o      = pending_q || (state_q == StIssue) || (state_q == StWait)
                         || (state_q == StStore);
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    assign error_o     = error_q;
`else
    assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_taylor_sweep_ctrl.sv
// Randomized bench for taylor_sweep_ctrl with a cosine engine model and a queue-based reference.
// Define TAYLOR_SWEEP_TIMEOUT_EN to exercise the WAIT watchdog instead of the no-timeout path.
module tb_taylor_sweep_ctrl;

    localparam int W     = 25;
    localparam int DEPTH = 8;

    logic         clock;
    logic         reset;
    logic         sweep_go;
    logic [W-1:0] angle_first, angle_step;
    logic [7:0]   sweep_len;
    logic         eng_start;
    logic [W-1:0] eng_angle;
    logic         eng_ready;
    logic [W-1:0] eng_cos;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ready;
    logic         busy, done, error;

    taylor_sweep_ctrl #(
        .W         (W),
        .DEPTH     (DEPTH),
        .ISSUE_CYC (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sweep_go_i    (sweep_go),
        .angle_first_i (angle_first),
        .angle_step_i  (angle_step),
        .sweep_len_i   (sweep_len),
        .eng_start_o   (eng_start),
        .eng_angle_o   (eng_angle),
        .eng_ready_i   (eng_ready),
        .eng_cos_i     (eng_cos),
        .res_valid_o   (res_valid),
        .res_data_o    (res_data),
        .res_ready_i   (res_ready),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic signed [W-1:0] cos_fx(input logic signed [W-1:0] a);
        real x, c;
        x = $itor(a) / 8388608.0;
        c = $cos(x) * 8388608.0;
        if (c >= 0.0) return W'($rtoi(c + 0.5));
        else return W'(-$rtoi(0.5 - c));
    endfunction

    // Engine model: drops ready on start, answers a few cycles after start falls.
    logic         stall;
    int           lat;
    logic [W-1:0] eng_ang_l;
    always @(posedge clock) begin
        if (reset) begin
            eng_ready <= 1'b1;
            eng_cos   <= W'(5);
            lat       <= 0;
        end else if (eng_start) begin
            eng_ready <= 1'b0;
            eng_ang_l <= eng_angle;
            lat       <= int'($urandom_range(1, 6));
        end else if (lat == 1 && !stall) begin
            eng_ready <= 1'b1;
            eng_cos   <= cos_fx(eng_ang_l);
            lat       <= 0;
        end else if (lat > 1) begin
            lat <= lat - 1;
        end
    end

    // Reference model: expected angle per request and result per delivery, in order.
    logic signed [W-1:0] exp_ang_q[$];
    logic signed [W-1:0] exp_res_q[$];
    logic signed [W-1:0] cur_exp_ang;
    int   rdy_mode  = 1;
    int   done_cnt  = 0;
    int   delivered = 0;
    int   n_issue   = 0;
    logic start_prev = 1'b0;

    always @(negedge clock) begin
        case (rdy_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset) begin
            start_prev = 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) check_eq("res_unexpected", exp_res_q.size(), 1);
                else check_eq("res_data", $signed(res_data), exp_res_q.pop_front());
                delivered++;
            end
            if (eng_start) begin
                if (!start_prev) begin
                    n_issue++;
                    if (exp_ang_q.size() == 0) check_eq("issue_unexpected", exp_ang_q.size(), 1);
                    else cur_exp_ang = exp_ang_q.pop_front();
                end
                check_eq("eng_angle", $signed(eng_angle), cur_exp_ang);
            end
            start_prev = eng_start;
            if (done) done_cnt++;
        end
    end

    task automatic start_sweep(input logic [W-1:0] first, input logic [W-1:0] step, input int len);
        logic [W-1:0] a;
        a = first;
        for (int i = 0; i < len; i++) begin
            exp_ang_q.push_back(a);
            exp_res_q.push_back(cos_fx(a));
            a = a + step;
        end
        @(negedge clock);
        sweep_go    = 1'b1;
        angle_first = first;
        angle_step  = step;
        sweep_len   = 8'(len);
        @(negedge clock);
        sweep_go    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_done_timeout"}, (done_cnt > base) ? 1 : 0, 1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_res_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check_eq({tag, "_drain"}, exp_res_q.size(), 0);
    endtask

    task automatic run_sweep(input string tag, input logic [W-1:0] first, input logic [W-1:0] step,
                             input int len, input int mode);
        int base_done, base_del;
        rdy_mode  = mode;
        base_done = done_cnt;
        base_del  = delivered;
        start_sweep(first, step, len);
        check_eq({tag, "_busy"}, busy, 1);
        wait_done(tag, base_done, 4000);
        drain(tag, 4000);
        check_eq({tag, "_done_pulses"}, done_cnt - base_done, 1);
        check_eq({tag, "_delivered"}, delivered - base_del, len);
        check_eq({tag, "_error"}, error, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_eng_start"}, eng_start, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_error"}, error, 0);
        check_eq({tag, "_eng_angle"}, eng_angle, 0);
        check_eq({tag, "_res_data"}, res_data, 0);
    endtask

    task automatic stall_to_wait(input string tag, input int len);
        int n;
        stall = 1'b1;
        start_sweep(W'(0), W'(1048576), len);
        n = 0;
        while (!eng_start && n < 50) begin @(negedge clock); n++; end
        while (eng_start && n < 50) begin @(negedge clock); n++; end
        check_eq({tag, "_reach_wait"}, (n < 50) ? 1 : 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base_done, base_issue, base_del, n;
        reset       = 1'b1;
        sweep_go    = 1'b0;
        angle_first = '0;
        angle_step  = '0;
        sweep_len   = '0;
        stall       = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_sweep("single_zero", W'(0), W'(0), 1, 1);
        run_sweep("quarter_steps", W'(0), W'(2097152), 4, 1);
        run_sweep("neg_wrap", W'(-15000000), W'(-2000000), 5, 2);

        for (int t = 0; t < 6; t++) begin
            run_sweep("random", W'($urandom()), W'($urandom()), int'($urandom_range(1, 20)), 2);
        end

        // Go pulsed while busy must not start anything.
        rdy_mode  = 2;
        base_done = done_cnt;
        base_del  = delivered;
        start_sweep(W'(100000), W'(300000), 6);
        repeat (4) @(negedge clock);
        check_eq("go_busy_busy", busy, 1);
        sweep_go    = 1'b1;
        angle_first = W'(7777777);
        sweep_len   = 8'd3;
        @(negedge clock);
        sweep_go    = 1'b0;
        wait_done("go_busy", base_done, 4000);
        drain("go_busy", 4000);
        check_eq("go_busy_delivered", delivered - base_del, 6);
        check_eq("go_busy_done_pulses", done_cnt - base_done, 1);

        // Back-pressure: buffer fills to DEPTH and issuing stalls.
        rdy_mode   = 0;
        base_done  = done_cnt;
        base_del   = delivered;
        base_issue = n_issue;
        start_sweep(W'(-3000000), W'(500000), 12);
        repeat (300) @(negedge clock);
        check_eq("full_issued", n_issue - base_issue, DEPTH);
        check_eq("full_eng_start", eng_start, 0);
        check_eq("full_res_valid", res_valid, 1);
        check_eq("full_busy", busy, 1);
        check_eq("full_no_done", done_cnt - base_done, 0);
        rdy_mode = 1;
        wait_done("full", base_done, 4000);
        drain("full", 4000);
        check_eq("full_delivered", delivered - base_del, 12);

        // Zero-length sweep.
        base_done  = done_cnt;
        base_issue = n_issue;
        start_sweep(W'(12345), W'(1), 0);
        check_eq("len0_done", done, 1);
        repeat (4) @(negedge clock);
        check_eq("len0_issues", n_issue - base_issue, 0);
        check_eq("len0_done_pulses", done_cnt - base_done, 1);

        // Reset in the middle of WAIT.
        base_done = done_cnt;
        stall_to_wait("rst_wait", 3);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("rst_wait");
        check_eq("rst_wait_no_done", done_cnt - base_done, 0);
        reset = 1'b0;
        exp_ang_q.delete();
        exp_res_q.delete();
        stall = 1'b0;
        run_sweep("after_reset", W'(4194304), W'(-1048576), 7, 2);

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
        base_done = done_cnt;
        stall_to_wait("timeout", 3);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("timeout_cycles", n, 64);
        check_eq("timeout_error", error, 1);
        repeat (3) @(negedge clock);
        check_eq("timeout_done_pulses", done_cnt - base_done, 1);
        check_eq("timeout_busy", busy, 0);
        check_eq("timeout_error_sticky", error, 1);
`else
        base_done = done_cnt;
        stall_to_wait("no_timeout", 3);
        repeat (100) @(negedge clock);
        check_eq("no_timeout_error", error, 0);
        check_eq("no_timeout_no_done", done_cnt - base_done, 0);
        check_eq("no_timeout_busy", busy, 1);
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_ang_q.delete();
        exp_res_q.delete();
        stall = 1'b0;
        base_del = delivered;
        run_sweep("final", W'(0), W'(2097152), 3, 1);
        check_eq("final_total", delivered - base_del, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/taylor_sweep_ctrl.md
TAYLOR_SWEEP_CTRL -- requirements
Module: taylor_sweep_ctrl

Interface
REQ-001 Parameter W, default 25, fixed-point word width of angles and results (signed, 23 fractional bits).
REQ-002 Parameter DEPTH, default 8, result buffer entries (power of two, 2..64).
REQ-003 Parameter ISSUE_CYC, default 3, cycles eng_start is held per request.
REQ-004 clock  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sweep_go  in  1  one-cycle request to start a sweep; sampled only in IDLE.
REQ-007 angle_first  in  W  first angle of the sweep; sampled with sweep_go.
REQ-008 angle_step  in  W  signed angle increment; sampled with sweep_go.
REQ-009 sweep_len  in  8  number of angles to evaluate (0..255); sampled with sweep_go.
REQ-010 eng_start  out  1  start request to the cosine engine.
REQ-011 eng_angle  out  W  angle presented to the engine.
REQ-012 eng_ready  in  1  engine result-ready flag.
REQ-013 eng_cos  in  W  engine cosine result.
REQ-014 res_valid / res_data  out  1 / W  result stream, head of the buffer.
REQ-015 res_ready  in  1  consumer accepts head when res_valid and res_ready are both high.
REQ-016 busy  out  1  high from the cycle after accepted sweep_go until done.
REQ-017 done  out  1  one-cycle pulse when the final result is written to the buffer.
REQ-018 error  out  1  sticky watchdog flag (see Configuration).

Function
REQ-019 States: IDLE, ISSUE, WAIT, STORE, FINISH; the controller SHALL never assert eng_start outside ISSUE.
REQ-020 IDLE: on sweep_go, latch the inputs, set remaining = sweep_len and cur_angle = angle_first; go to FINISH if sweep_len = 0, else go to ISSUE once the buffer has a free slot.
REQ-021 ISSUE: drive eng_start = 1 and eng_angle = cur_angle for exactly ISSUE_CYC cycles, then go to WAIT.
REQ-022 eng_angle SHALL remain stable from the first ISSUE cycle until the STORE cycle for that request.
REQ-023 WAIT: ignore eng_ready until it has been sampled low at least once (discards the stale ready from the previous request); then, on the first cycle eng_ready = 1, capture eng_cos and go to STORE.
REQ-024 STORE: push the captured value, cur_angle += angle_step (modulo 2^W, wrap without saturation), remaining -= 1.
REQ-025 STORE exit: go to FINISH if remaining reaches 0; otherwise go to ISSUE if a free slot exists, else stay in STORE without pushing again.
REQ-026 Free slot SHALL mean buffer occupancy < DEPTH, counting the entry not yet pushed; a full buffer SHALL stall issuing, and no result SHALL ever be dropped.
REQ-027 FINISH: pulse done for one cycle, drop busy, and return to IDLE.
REQ-028 Buffer is FIFO-ordered; res_valid = not empty.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged; a pop on an empty buffer is ignored.
REQ-030 sweep_go received while busy SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE and clear the buffer.
REQ-032 Reset SHALL drive eng_start, res_valid, busy, done and error to 0, and eng_angle and res_data to 0.
REQ-033 A reset during any state SHALL abort the sweep, with no done pulse.

Configuration
REQ-034 With TAYLOR_SWEEP_TIMEOUT_EN defined, WAIT SHALL count cycles.
REQ-035 After 64 cycles in WAIT without a capture, the controller SHALL set error, pulse done and return to IDLE; results already buffered are kept.
REQ-036 Without TAYLOR_SWEEP_TIMEOUT_EN, WAIT has no timeout and error SHALL be tied to 0.

Structure
REQ-037 Package taylor_pkg SHALL hold: W, FRAC = 23, FXP_ONE = 8388608, and the controller state enum typedef.
REQ-038 The result buffer SHALL be a sub-module taylor_result_fifo (parameters W, DEPTH; push, pop, full, empty, count).

Verification
REQ-039 angle_first 0, sweep_len 1 -> res_data 8388608 (about 1.0, within 2 LSB); done pulses once.
REQ-040 angle_first 0, step 2097152, sweep_len 4 -> 4 results in order matching cos(0, 0.25, 0.5, 0.75) within 8 LSB; eng_angle wraps correctly with a negative step.
REQ-041 res_ready held 0, sweep_len 12, DEPTH 8 -> exactly 8 results buffered and eng_start idle; release res_ready -> all 12 results delivered with none lost.
REQ-042 sweep_len 0 -> done the cycle after IDLE exit, eng_start never asserted.
REQ-043 reset asserted mid-WAIT -> all outputs 0 next cycle; a following sweep_go runs normally.
REQ-044 TAYLOR_SWEEP_TIMEOUT_EN defined, engine model holds eng_ready 0 -> error = 1 and done pulse 64 cycles after WAIT entry.
